// File: rtl/cache_sim_defs_pkg.sv
// Shared definitions for the cache-simulator hierarchy blocks:
// FSM state encodings, common width defaults and a clog2 helper.
package cache_sim_defs;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } state_e;

  localparam int DEF_ADDR_W = 32;
  localparam int DEF_CNT_W  = 20;

  function automatic int clog2_f(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/rr_priority_picker.sv
// Combinational round-robin picker: scans req upward from last+1,
// wrapping modulo N. Ports: req, last -> found, idx.
module rr_priority_picker
  import cache_sim_defs::*;
#(
  parameter int N  = 4,
  parameter int IW = clog2_f(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last,
  output logic          found,
  output logic [IW-1:0] idx
);

  logic [IW-1:0] cand;

  // N is a power of two, so IW-bit addition wraps for free;
  // k == N lands back on last itself as the final candidate.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    cand  = '0;
    for (int k = 1; k <= N; k++) begin
      cand = last + IW'(k);
      if (!found && req[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
    end
  end

endmodule

// File: rtl/core_trace_arbiter.sv
// Round-robin scheduler sharing one cache hierarchy among trace cores.
// Ports: req_valid/req_addr/req_ready per core; mem_addr/trace_ready/
// updated to hierarchy; grant_core, busy, timeout_err, issued_count.
module core_trace_arbiter
  import cache_sim_defs::*;
#(
  parameter int NUM_CORES = 4,
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int CNT_W     = DEF_CNT_W,
  parameter int TIMEOUT   = 1023,
  parameter int GW        = clog2_f(NUM_CORES)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_CORES-1:0]      req_valid,
  input  logic [NUM_CORES*ADDR_W-1:0] req_addr,
  output logic [NUM_CORES-1:0]      req_ready,
  output logic [ADDR_W-1:0]         mem_addr,
  output logic                      trace_ready,
  input  logic                      updated,
  output logic [GW-1:0]             grant_core,
  output logic                      busy,
  output logic                      timeout_err,
  output logic [NUM_CORES*CNT_W-1:0] issued_count
);

  localparam int WW = clog2_f(TIMEOUT);

  state_e         state;
  logic [GW-1:0]  last_grant;
  logic [WW-1:0]  wd;
  logic [CNT_W-1:0] cnt [NUM_CORES];

  logic           pick_found;
  logic [GW-1:0]  pick_idx;

  rr_priority_picker #(
    .N  (NUM_CORES),
    .IW (GW)
  ) u_pick (
    .req   (req_valid),
    .last  (last_grant),
    .found (pick_found),
    .idx   (pick_idx)
  );

  for (genvar g = 0; g < NUM_CORES; g++) begin : g_cnt
    assign issued_count[g*CNT_W +: CNT_W] = cnt[g];
  end

  // Outputs are registered, so the ISSUE-cycle pulses are
  // loaded on the IDLE->ISSUE edge and cleared on the next one.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_IDLE;
      last_grant  <= GW'(NUM_CORES - 1);
      wd          <= '0;
      mem_addr    <= '0;
      grant_core  <= '0;
      req_ready   <= '0;
      trace_ready <= 1'b0;
      busy        <= 1'b0;
      timeout_err <= 1'b0;
      for (int k = 0; k < NUM_CORES; k++) cnt[k] <= '0;
    end else begin
      trace_ready <= 1'b0;
      req_ready   <= '0;
      unique case (state)
        ST_IDLE: begin
          if (pick_found) begin
            mem_addr    <= req_addr[pick_idx*ADDR_W +: ADDR_W];
            grant_core  <= pick_idx;
            trace_ready <= 1'b1;
            req_ready   <= NUM_CORES'(1) << pick_idx;
            busy        <= 1'b1;
            state       <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          wd    <= '0;
          state <= ST_WAIT;
        end
        ST_WAIT: begin
          // Completion takes priority over a same-cycle expiry.
          if (updated) begin
            if (cnt[grant_core] != '1)
              cnt[grant_core] <= cnt[grant_core] + 1'b1;
            last_grant <= grant_core;
            busy       <= 1'b0;
            state      <= ST_IDLE;
          end else if (wd == WW'(TIMEOUT - 1)) begin
            timeout_err <= 1'b1;
            last_grant  <= grant_core;
            busy        <= 1'b0;
            state       <= ST_IDLE;
          end else begin
            wd <= wd + 1'b1;
          end
        end
        default: begin
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_core_trace_arbiter.sv
// Self-checking bench for core_trace_arbiter: vector table plus
// hand sequences, with an issue scoreboard checked by a monitor.
module tb_core_trace_arbiter;

  localparam int NC = 4;
  localparam int AW = 32;
  localparam int CW = 3;
  localparam int TO = 8;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic [NC-1:0]     req_valid = '0;
  logic [NC*AW-1:0]  req_addr = '0;
  logic              updated = 1'b0;
  logic [NC-1:0]     req_ready;
  logic [AW-1:0]     mem_addr;
  logic              trace_ready;
  logic [1:0]        grant_core;
  logic              busy;
  logic              timeout_err;
  logic [NC*CW-1:0]  issued_count;

  core_trace_arbiter #(
    .NUM_CORES (NC),
    .ADDR_W    (AW),
    .CNT_W     (CW),
    .TIMEOUT   (TO)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_addr     (req_addr),
    .req_ready    (req_ready),
    .mem_addr     (mem_addr),
    .trace_ready  (trace_ready),
    .updated      (updated),
    .grant_core   (grant_core),
    .busy         (busy),
    .timeout_err  (timeout_err),
    .issued_count (issued_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]    core;
    logic [AW-1:0] addr;
  } exp_t;

  typedef struct {
    logic [NC-1:0] valid;
    int            core;
    int            dly;
  } vec_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_run = 0;
  int   n_fail = 0;
  int   mcnt[NC];

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (trace_ready === 1'b1) begin
      if (sb.size() == 0) begin
        n_run++;
        n_fail++;
        $display("FAIL sb_underflow: issue with no expected entry");
      end else begin
        mon_e = sb.pop_front();
        chk("grant", grant_core, mon_e.core);
        chk("addr", mem_addr, mon_e.addr);
        chk("ready_onehot", req_ready, 4'b0001 << mon_e.core);
      end
    end
  end

  function automatic logic [NC*CW-1:0] model_cnt();
    logic [NC*CW-1:0] r;
    r = '0;
    for (int i = 0; i < NC; i++) r[i*CW +: CW] = CW'(mcnt[i]);
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rand_addrs();
    for (int i = 0; i < NC; i++)
      req_addr[i*AW +: AW] = $urandom() & 32'hFFFF_FFFC;
  endtask

  task automatic push_exp(input int core);
    exp_t e;
    e.core = 2'(core);
    e.addr = req_addr[core*AW +: AW];
    sb.push_back(e);
  endtask

  task automatic check_zero(input string nm);
    chk({nm, "_trace_ready"}, trace_ready, 0);
    chk({nm, "_req_ready"}, req_ready, 0);
    chk({nm, "_busy"}, busy, 0);
    chk({nm, "_timeout_err"}, timeout_err, 0);
    chk({nm, "_grant"}, grant_core, 0);
    chk({nm, "_mem_addr"}, mem_addr, 0);
    chk({nm, "_count"}, issued_count, 0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    req_valid = '0;
    updated = 1'b0;
    tick();
    tick();
    check_zero("rst");
    reset = 1'b0;
    for (int i = 0; i < NC; i++) mcnt[i] = 0;
    sb.delete();
  endtask

  // One full access: request, expect issue next cycle,
  // updated dly cycles after the issue cycle.
  task automatic access(input logic [NC-1:0] v, input int core,
                        input int dly);
    int n;
    push_exp(core);
    req_valid = v;
    tick();
    n = 1;
    while (!trace_ready && n < 8) begin
      tick();
      n++;
    end
    chk("issue_lat", n, 1);
    if (!trace_ready) begin
      req_valid = '0;
      return;
    end
    req_valid = v & ~(NC'(1) << core);
    repeat (dly) tick();
    chk("addr_hold", mem_addr, req_addr[core*AW +: AW]);
    chk("busy_wait", busy, 1);
    updated = 1'b1;
    tick();
    updated = 1'b0;
    req_valid = '0;
    chk("busy_done", busy, 0);
    if (mcnt[core] < (1 << CW) - 1) mcnt[core]++;
    chk("count", issued_count, model_cnt());
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t tbl[12];
    tbl[0]  = '{4'b1111, 0, 3};
    tbl[1]  = '{4'b1111, 1, 3};
    tbl[2]  = '{4'b1111, 2, 3};
    tbl[3]  = '{4'b1111, 3, 3};
    tbl[4]  = '{4'b1111, 0, 3};
    tbl[5]  = '{4'b0100, 2, 2};
    tbl[6]  = '{4'b0011, 0, 4};
    tbl[7]  = '{4'b1010, 1, 1};
    tbl[8]  = '{4'b1001, 3, 2};
    tbl[9]  = '{4'b1001, 0, 3};
    tbl[10] = '{4'b1000, 3, 1};
    tbl[11] = '{4'b0110, 1, 5};

    do_reset();

    // Single core0 access, updated at t+6.
    req_addr[0 +: AW] = 32'h0000_1230;
    access(4'b0001, 0, 5);
    chk("t1_cnt0", issued_count[0 +: CW], 1);

    // Round-robin vector table.
    do_reset();
    for (int i = 0; i < 12; i++) begin
      rand_addrs();
      access(tbl[i].valid, tbl[i].core, tbl[i].dly);
      if (i == 3) chk("rr_all_once", issued_count, 12'b001001001001);
    end

    // Watchdog abort on core2, then core3 still served.
    rand_addrs();
    push_exp(2);
    req_valid = 4'b0100;
    tick();
    chk("t3_issue", trace_ready, 1);
    req_valid = '0;
    repeat (TO) tick();
    chk("t3_pre_err", timeout_err, 0);
    chk("t3_pre_busy", busy, 1);
    tick();
    chk("t3_err", timeout_err, 1);
    chk("t3_busy", busy, 0);
    chk("t3_cnt", issued_count, model_cnt());
    rand_addrs();
    access(4'b1000, 3, 2);
    chk("t3_sticky", timeout_err, 1);

    // Reset in WAIT of a core1 access.
    rand_addrs();
    push_exp(1);
    req_valid = 4'b0010;
    tick();
    chk("t4_issue", trace_ready, 1);
    req_valid = '0;
    tick();
    tick();
    reset = 1'b1;
    tick();
    check_zero("t4");
    reset = 1'b0;
    for (int i = 0; i < NC; i++) mcnt[i] = 0;
    rand_addrs();
    access(4'b0011, 0, 2);
    access(4'b0010, 1, 2);

    // updated on the watchdog's last cycle: completion wins.
    do_reset();
    rand_addrs();
    access(4'b0010, 1, TO);
    chk("coincide_no_err", timeout_err, 0);

    // updated in IDLE and in ISSUE is ignored.
    updated = 1'b1;
    tick();
    updated = 1'b0;
    chk("t5_idle_busy", busy, 0);
    chk("t5_idle_cnt", issued_count, model_cnt());
    rand_addrs();
    push_exp(0);
    req_valid = 4'b0001;
    tick();
    chk("t5_issue", trace_ready, 1);
    updated = 1'b1;
    req_valid = '0;
    tick();
    updated = 1'b0;
    chk("t5_issue_cnt", issued_count, model_cnt());
    chk("t5_wait_busy", busy, 1);
    repeat (2) tick();
    updated = 1'b1;
    tick();
    updated = 1'b0;
    mcnt[0]++;
    chk("t5_done_cnt", issued_count, model_cnt());
    chk("t5_done_busy", busy, 0);

    // Counter saturation.
    do_reset();
    repeat (9) begin
      rand_addrs();
      access(4'b0001, 0, 1);
    end
    chk("sat", issued_count, 12'b000000000111);

    tick();
    tick();
    chk("sb_drain", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
